// File: rtl/decode_stage_pipe.sv
// Decode stage for the pipelined core: instruction decode, 2R1W register file with
// writeback bypass, load-use hazard detection and the registered ID/EX boundary.
module decode_stage_pipe #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned DEBUG_REG = 10,
  localparam int unsigned RW       = $clog2(REG_COUNT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid_i,
  input  logic [31:0]     id_instr_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic            wb_we_i,
  input  logic [RW-1:0]   wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            ex_hold_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            illegal_o,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [XLEN-1:0] ex_rd1_o,
  output logic [XLEN-1:0] ex_rd2_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [RW-1:0]   ex_rs1_o,
  output logic [RW-1:0]   ex_rs2_o,
  output logic [RW-1:0]   ex_rd_o,
  output logic [2:0]      ex_funct3_o,
  output logic            ex_funct7b5_o,
  output logic [6:0]      ex_opcode_o,
  output logic            ex_reg_write_o,
  output logic            ex_mem_read_o,
  output logic            ex_mem_write_o,
  output logic            ex_branch_o,
  output logic            ex_jump_o,
  output logic            ex_alu_src_b_o,
  output logic [XLEN-1:0] dbg_reg_o
);

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [6:0]      opcode;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            alu_src_b;
  } idex_t;

  logic [XLEN-1:0] rf_q [REG_COUNT];
  idex_t           idex_q, idex_d, decoded;

  logic [6:0]      opcode;
  logic [RW-1:0]   rs1, rs2, rd;
  logic [31:0]     imm_i, imm_s, imm_b, imm_j, imm_u, imm32;
  logic            legal, use_rs1, use_rs2, hazard;
  logic            reg_write, mem_read, mem_write, branch, jump, alu_src_b;
  logic [XLEN-1:0] rd1, rd2;

  assign opcode = id_instr_i[6:0];
  assign rd     = id_instr_i[7 +: RW];
  assign rs1    = id_instr_i[15 +: RW];
  assign rs2    = id_instr_i[20 +: RW];

  assign imm_i = {{20{id_instr_i[31]}}, id_instr_i[31:20]};
  assign imm_s = {{20{id_instr_i[31]}}, id_instr_i[31:25], id_instr_i[11:7]};
  assign imm_b = {{19{id_instr_i[31]}}, id_instr_i[31], id_instr_i[7], id_instr_i[30:25],
                  id_instr_i[11:8], 1'b0};
  assign imm_j = {{11{id_instr_i[31]}}, id_instr_i[31], id_instr_i[19:12], id_instr_i[20],
                  id_instr_i[30:21], 1'b0};
  assign imm_u = {id_instr_i[31:12], 12'h000};

  always_comb begin
    legal     = 1'b1;
    use_rs1   = 1'b1;
    use_rs2   = 1'b0;
    imm32     = '0;
    reg_write = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    alu_src_b = 1'b1;
    case (opcode)
      OpcOp: begin
        use_rs2   = 1'b1;
        alu_src_b = 1'b0;
      end
      OpcOpImm: imm32 = imm_i;
      OpcLoad: begin
        imm32    = imm_i;
        mem_read = 1'b1;
      end
      OpcJalr: begin
        imm32 = imm_i;
        jump  = 1'b1;
      end
      OpcStore: begin
        imm32     = imm_s;
        use_rs2   = 1'b1;
        reg_write = 1'b0;
        mem_write = 1'b1;
      end
      OpcBranch: begin
        imm32     = imm_b;
        use_rs2   = 1'b1;
        reg_write = 1'b0;
        branch    = 1'b1;
        alu_src_b = 1'b0;
      end
      OpcJal: begin
        imm32   = imm_j;
        use_rs1 = 1'b0;
        jump    = 1'b1;
      end
      OpcLui, OpcAuipc: begin
        imm32   = imm_u;
        use_rs1 = 1'b0;
      end
      default: begin
        // Unsupported opcodes read no sources so they can never raise a hazard.
        legal     = 1'b0;
        use_rs1   = 1'b0;
        reg_write = 1'b0;
        alu_src_b = 1'b0;
      end
    endcase
  end

  // Reads see a same-cycle writeback to the same register.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs1 != '0) rd1 = (wb_we_i && wb_rd_i == rs1) ? wb_data_i : rf_q[rs1];
    if (rs2 != '0) rd2 = (wb_we_i && wb_rd_i == rs2) ? wb_data_i : rf_q[rs2];
  end

  assign hazard = idex_q.valid & idex_q.mem_read & (idex_q.rd != '0) & id_valid_i &
                  ((use_rs1 & (rs1 == idex_q.rd)) | (use_rs2 & (rs2 == idex_q.rd)));

  assign stall_o   = (hazard | ex_hold_i) & ~flush_i;
  assign illegal_o = id_valid_i & ~legal;

  always_comb begin
    decoded           = '0;
    decoded.valid     = 1'b1;
    decoded.pc        = id_pc_i;
    decoded.rd1       = rd1;
    decoded.rd2       = rd2;
    decoded.imm       = XLEN'($signed(imm32));
    decoded.rs1       = rs1;
    decoded.rs2       = rs2;
    decoded.rd        = rd;
    decoded.funct3    = id_instr_i[14:12];
    decoded.funct7b5  = id_instr_i[30];
    decoded.opcode    = opcode;
    decoded.reg_write = reg_write;
    decoded.mem_read  = mem_read;
    decoded.mem_write = mem_write;
    decoded.branch    = branch;
    decoded.jump      = jump;
    decoded.alu_src_b = alu_src_b;
  end

  always_comb begin
    idex_d = idex_q;
    if (flush_i) begin
      idex_d = '0;
    end else if (!ex_hold_i) begin
      if (hazard || !id_valid_i || !legal) idex_d = '0;
      else                                 idex_d = decoded;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
    end else if (wb_we_i && wb_rd_i != '0) begin
      rf_q[wb_rd_i] <= wb_data_i;
    end
  end

  assign ex_valid_o     = idex_q.valid;
  assign ex_pc_o        = idex_q.pc;
  assign ex_rd1_o       = idex_q.rd1;
  assign ex_rd2_o       = idex_q.rd2;
  assign ex_imm_o       = idex_q.imm;
  assign ex_rs1_o       = idex_q.rs1;
  assign ex_rs2_o       = idex_q.rs2;
  assign ex_rd_o        = idex_q.rd;
  assign ex_funct3_o    = idex_q.funct3;
  assign ex_funct7b5_o  = idex_q.funct7b5;
  assign ex_opcode_o    = idex_q.opcode;
  assign ex_reg_write_o = idex_q.reg_write;
  assign ex_mem_read_o  = idex_q.mem_read;
  assign ex_mem_write_o = idex_q.mem_write;
  assign ex_branch_o    = idex_q.branch;
  assign ex_jump_o      = idex_q.jump;
  assign ex_alu_src_b_o = idex_q.alu_src_b;
  assign dbg_reg_o      = rf_q[RW'(DEBUG_REG)];

endmodule
